// File: rtl/fifo_logic_gated.sv
// FT2232H <-> dual-FIFO bridge: moves one byte per handshake between FIFO B -> USB
// (write) and USB -> FIFO A (read), with fair arbitration and timeout-bounded waits.
module fifo_logic_gated (
    input  logic clk,
    input  logic rst_n,
    input  logic FFA,
    input  logic EFB,
    input  logic RXF,
    input  logic TXE,
    output logic RD,
    output logic WR,
    output logic RB,
    output logic WA,
    output logic D1,
    output logic D2
);

    typedef enum logic [3:0] {
        IDLE,
        W_FETCH,
        W_STROBE,
        W_COMMIT,
        W_WAIT,
        R_ASSERT,
        R_CAPTURE,
        R_RELEASE,
        R_WAIT
    } state_t;

    // Output vector layout: {D2, D1, WA, RB, WR, RD}
    localparam int          NOUT    = 6;
    localparam logic [NOUT-1:0] OUT_IDLE = 6'b001101;

    state_t          state_reg, state_next;
    logic [2:0]      cnt_reg, cnt_next;
    logic            last_wr_reg, last_wr_next;
    logic [NOUT-1:0] out_reg, out_next;
    logic            wr_req, rd_req;

    assign wr_req = !TXE && EFB;
    assign rd_req = !RXF && FFA;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        last_wr_next = last_wr_reg;
        case (state_reg)
            IDLE: begin
                // Contention goes to whichever direction was not served last
                if (rd_req && (!wr_req || last_wr_reg)) begin
                    state_next   = R_ASSERT;
                    last_wr_next = 1'b0;
                end else if (wr_req) begin
                    state_next   = W_FETCH;
                    last_wr_next = 1'b1;
                end
            end
            W_FETCH:   state_next = W_STROBE;
            W_STROBE:  state_next = W_COMMIT;
            W_COMMIT: begin
                state_next = W_WAIT;
                cnt_next   = 3'd0;
            end
            W_WAIT: begin
                if (TXE || cnt_reg == 3'd7) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            R_ASSERT:  state_next = R_CAPTURE;
            R_CAPTURE: state_next = R_RELEASE;
            R_RELEASE: begin
                state_next = R_WAIT;
                cnt_next   = 3'd0;
            end
            R_WAIT: begin
                if (RXF || cnt_reg == 3'd7) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered strobes line up with the state
    always_comb begin
        out_next = OUT_IDLE;
        case (state_next)
            W_FETCH:   out_next = 6'b011001;
            W_STROBE:  out_next = 6'b011111;
            W_COMMIT:  out_next = 6'b011101;
            W_WAIT:    out_next = 6'b011101;
            R_ASSERT:  out_next = 6'b101100;
            R_CAPTURE: out_next = 6'b100100;
            R_RELEASE: out_next = 6'b101101;
            R_WAIT:    out_next = 6'b101101;
            default:   out_next = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= 3'd0;
            last_wr_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            last_wr_reg <= last_wr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NOUT; gi++) begin : g_out
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_reg[gi] <= OUT_IDLE[gi];
                end else begin
                    out_reg[gi] <= out_next[gi];
                end
            end
        end
    endgenerate

    assign RD = out_reg[0];
    assign WR = out_reg[1];
    assign RB = out_reg[2];
    assign WA = out_reg[3];
    assign D1 = out_reg[4];
    assign D2 = out_reg[5];

endmodule

// File: tb/tb_fifo_logic_gated.sv
// Directed bench for fifo_logic_gated: per-byte scoreboard of transfer direction plus
// per-clock strobe width, pairing and exclusivity checks sampled on the falling edge.
module tb_fifo_logic_gated;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic FFA = 1'b0, EFB = 1'b0, RXF = 1'b1, TXE = 1'b1;
    logic RD, WR, RB, WA, D1, D2;

    always #5 clk = ~clk;

    fifo_logic_gated dut (
        .clk(clk), .rst_n(rst_n), .FFA(FFA), .EFB(EFB), .RXF(RXF), .TXE(TXE),
        .RD(RD), .WR(WR), .RB(RB), .WA(WA), .D1(D1), .D2(D2)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];          // 0 = read byte, 1 = write byte
    logic prev_rd = 1'b1, prev_wr = 1'b0, prev_rb = 1'b1, prev_wa = 1'b1;
    logic prev_d1 = 1'b0, prev_d2 = 1'b0;
    int rd_low = 0, wr_high = 0, rb_low = 0, wa_low = 0;
    int rb_since = 0, wa_since = 0;
    int n_rd = 0, n_wr = 0, n_rb = 0, n_wa = 0;
    int toggles = 0, tick_no = 0, last_fall = 0, wr_gap = 0;
    int auto_txe = 0, auto_rxf = 0, txe_cnt = 0, rxf_cnt = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic sb_pop(input int kind);
        int e;
        chk("sb_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_direction", kind, e);
        end
        $display("txn %0d: %s byte completed at %0t", n_rd + n_wr, kind ? "write" : "read", $time);
    endtask

    task automatic tick();
        logic wr_fell, rd_rose;
        @(negedge clk);
        tick_no++;
        wr_fell = 1'b0;
        rd_rose = 1'b0;
        chk("d1_d2_exclusive", int'(D1 & D2), 0);
        chk("rd_wr_exclusive", int'(!RD & WR), 0);
        if (!RB) chk("rb_inside_write", int'(D1), 1);
        if (WR)  chk("wr_inside_write", int'(D1), 1);
        if (!RD) chk("rd_inside_read", int'(D2), 1);
        if (!WA) chk("wa_inside_rd_low", int'(RD), 0);
        if (RD != prev_rd || WR != prev_wr || RB != prev_rb || WA != prev_wa ||
            D1 != prev_d1 || D2 != prev_d2) toggles++;

        if (!RB) rb_low++;
        else if (!prev_rb) begin
            chk("rb_width", rb_low, 1);
            rb_low = 0; rb_since++; n_rb++;
        end
        if (WR) wr_high++;
        else if (prev_wr) begin
            chk("wr_width", wr_high, 1);
            chk("rb_per_wr", rb_since, 1);
            wr_high = 0; rb_since = 0; n_wr++;
            wr_gap = tick_no - last_fall;
            last_fall = tick_no;
            wr_fell = 1'b1;
            sb_pop(1);
        end
        if (!WA) wa_low++;
        else if (!prev_wa) begin
            chk("wa_width", wa_low, 1);
            wa_low = 0; wa_since++; n_wa++;
        end
        if (!RD) rd_low++;
        else if (!prev_rd) begin
            chk("rd_low_width", rd_low, 2);
            chk("wa_per_rd", wa_since, 1);
            rd_low = 0; wa_since = 0; n_rd++;
            rd_rose = 1'b1;
            sb_pop(0);
        end

        // Bench-side flag responses: TXE high for 630 time units, RXF high for 3 clocks
        if (wr_fell && auto_txe != 0) begin
            TXE = 1'b1; txe_cnt = 63;
        end else if (txe_cnt > 0) begin
            txe_cnt--;
            if (txe_cnt == 0) TXE = 1'b0;
        end
        if (rd_rose && auto_rxf != 0) begin
            RXF = 1'b1; rxf_cnt = 3;
        end else if (rxf_cnt > 0) begin
            rxf_cnt--;
            if (rxf_cnt == 0) RXF = 1'b0;
        end

        prev_rd = RD; prev_wr = WR; prev_rb = RB; prev_wa = WA; prev_d1 = D1; prev_d2 = D2;
    endtask

    // which: 0 = reads, 1 = writes, 2 = reads + writes
    task automatic run_until(input int which, input int target, input int budget);
        int cnt;
        int got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            cnt = (which == 0) ? n_rd : (which == 1) ? n_wr : n_rd + n_wr;
            if (cnt >= target) begin
                got = 1;
                break;
            end
        end
        chk("byte_count_reached", got, 1);
    endtask

    initial begin
        int base_rd;
        int base_tot;
        int found;

        // Reset state
        repeat (3) tick();
        chk("reset_rd", int'(RD), 1);
        chk("reset_wr", int'(WR), 0);
        chk("reset_rb", int'(RB), 1);
        chk("reset_wa", int'(WA), 1);
        chk("reset_d1", int'(D1), 0);
        chk("reset_d2", int'(D2), 0);
        rst_n = 1'b1;

        // Idle: nothing requested for 50 clocks
        toggles = 0;
        repeat (50) tick();
        chk("idle_toggles", toggles, 0);
        chk("idle_rd", int'(RD), 1);
        chk("idle_rb", int'(RB), 1);

        // 20 USB writes with TXE raised after each WR falling edge
        for (int i = 0; i < 20; i++) exp_q.push_back(1);
        auto_txe = 1;
        FFA = 1'b1; EFB = 1'b1; RXF = 1'b1; TXE = 1'b0;
        run_until(1, 20, 3000);
        EFB = 1'b0;
        auto_txe = 0;
        repeat (70) tick();
        TXE = 1'b1;
        chk("write_rb_pulses", n_rb, 20);
        chk("write_wr_pulses", n_wr, 20);
        chk("write_no_reads", n_rd, 0);
        chk("write_d1_after", int'(D1), 0);
        chk("write_queue_drained", exp_q.size(), 0);

        // 40 USB reads with RXF raised after each RD rising edge
        for (int i = 0; i < 40; i++) exp_q.push_back(0);
        auto_rxf = 1;
        FFA = 1'b1; EFB = 1'b0; RXF = 1'b0; TXE = 1'b1;
        run_until(0, 40, 2000);
        FFA = 1'b0;
        auto_rxf = 0;
        repeat (10) tick();
        RXF = 1'b1;
        chk("read_rd_pulses", n_rd, 40);
        chk("read_wa_pulses", n_wa, 40);
        chk("read_no_writes", n_wr, 20);
        chk("read_d2_after", int'(D2), 0);
        chk("read_queue_drained", exp_q.size(), 0);

        // TXE stuck low: W_WAIT times out after 8 clocks, giving a 12-clock byte spacing
        for (int i = 0; i < 3; i++) exp_q.push_back(1);
        FFA = 1'b0; EFB = 1'b1; RXF = 1'b1; TXE = 1'b0;
        run_until(1, 22, 200);
        run_until(1, 23, 200);
        chk("w_wait_timeout_gap", wr_gap, 12);
        EFB = 1'b0;
        repeat (15) tick();
        TXE = 1'b1;

        // RXF low but FIFO A full: no read activity
        base_rd = n_rd;
        FFA = 1'b0; RXF = 1'b0;
        repeat (30) tick();
        chk("ffa_full_no_rd", n_rd, base_rd);
        chk("ffa_full_rd_high", int'(RD), 1);
        RXF = 1'b1;

        // Both directions requesting after reset: read first, then strict alternation
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(0);
            exp_q.push_back(1);
        end
        base_tot = n_rd + n_wr;
        FFA = 1'b1; EFB = 1'b1; RXF = 1'b0; TXE = 1'b0;
        run_until(2, base_tot + 6, 400);
        TXE = 1'b1; RXF = 1'b1;
        repeat (15) tick();
        chk("alt_queue_drained", exp_q.size(), 0);
        chk("alt_d1_after", int'(D1), 0);

        // Reset during R_CAPTURE aborts the byte at the next edge
        exp_q.push_back(0);
        FFA = 1'b1; EFB = 1'b0; RXF = 1'b0; TXE = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!RD && !WA) begin
                found = 1;
                break;
            end
        end
        chk("capture_reached", found, 1);
        rst_n = 1'b0;
        FFA = 1'b0; RXF = 1'b1;
        tick();
        chk("abort_rd", int'(RD), 1);
        chk("abort_wa", int'(WA), 1);
        chk("abort_d2", int'(D2), 0);
        tick();
        rst_n = 1'b1;
        base_rd = n_rd;
        toggles = 0;
        repeat (10) tick();
        chk("abort_no_more_rd", n_rd, base_rd);
        chk("abort_no_toggles", toggles, 0);
        chk("abort_queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_logic_gated.md
FIFO_LOGIC_GATED -- requirements
Module: fifo_logic_gated

Interface
REQ-001 The block SHALL expose these ports (name, direction, width, meaning):
  - clk  in  1  single system clock; all state updates on its rising edge.
  - rst_n  in  1  reset, synchronous, active-low.
  - FFA  in  1  FIFO A full flag, active-low (1 = FIFO A can accept a word).
  - EFB  in  1  FIFO B empty flag, active-low (1 = FIFO B holds data).
  - RXF  in  1  FT2232H RXF#, active-low (0 = USB receive data available).
  - TXE  in  1  FT2232H TXE#, active-low (0 = USB transmit buffer can accept a byte).
  - RD  out  1  FT2232H RD#, active-low read strobe.
  - WR  out  1  FT2232H WR strobe; byte committed on its falling edge.
  - RB  out  1  FIFO B read strobe, active-low.
  - WA  out  1  FIFO A write strobe, active-low.
  - D1  out  1  bus-direction enable, FIFO B -> USB path; active-high.
  - D2  out  1  bus-direction enable, USB -> FIFO A path; active-high.
REQ-002 All outputs SHALL be registered, with no combinational input-to-output paths.
REQ-003 The clock SHALL be allowed to be gated or irregular; behaviour SHALL be defined only in terms of clk rising edges.

Function
REQ-004 The FSM SHALL have these states: IDLE, W_FETCH, W_STROBE, W_COMMIT, W_WAIT, R_ASSERT, R_CAPTURE, R_RELEASE, R_WAIT.
REQ-005 In IDLE, the write request condition SHALL be TXE=0 and EFB=1.
REQ-006 In IDLE, the read request condition SHALL be RXF=0 and FFA=1.
REQ-007 In IDLE with only one request condition true, the FSM SHALL start that sequence on the next edge.
REQ-008 In IDLE with both request conditions true, the FSM SHALL serve the direction not served last; after reset, the read sequence goes first.
REQ-009 In IDLE with neither condition true, the FSM SHALL remain in IDLE with all outputs at their inactive levels.
REQ-010 Write sequence, one state per clock, in this order:
  - W_FETCH: RB=0, D1=1.
  - W_STROBE: RB=1, WR=1, D1=1.
  - W_COMMIT: WR=0, D1=1; this WR falling edge transfers exactly one byte to USB.
  - W_WAIT: D1=1; hold until TXE sampled 1 or 8 cycles elapse, then go to IDLE with D1=0.
REQ-011 Read sequence, one state per clock unless stated:
  - R_ASSERT: RD=0, D2=1.
  - R_CAPTURE: RD=0, WA=0, D2=1.
  - R_RELEASE: RD=1, WA=1, D2=1; this RD rising edge ends exactly one byte read.
  - R_WAIT: D2=1; hold until RXF sampled 1 or 8 cycles elapse, then go to IDLE with D2=0.
REQ-012 D1 and D2 SHALL never be 1 simultaneously.
REQ-013 RD=0 and WR=1 SHALL never occur simultaneously.
REQ-014 Exactly one RB pulse SHALL be issued per WR pulse.
REQ-015 Exactly one WA pulse SHALL be issued per RD pulse.
REQ-016 Each strobe (RB, WR, WA) SHALL last exactly one clock; the RD low pulse SHALL last exactly two clocks.
REQ-017 Flag changes after a sequence has started SHALL NOT abort it; the current byte always completes.
REQ-018 Flags SHALL be re-evaluated only in IDLE.
REQ-019 The W_WAIT and R_WAIT timeout counters SHALL be 3 bits wide, cleared on entry to the wait state.
REQ-020 Minimum spacing between back-to-back bytes in the same direction SHALL be 5 clocks.

Reset
REQ-021 While rst_n=0 at a clk edge, the FSM SHALL go to IDLE, clear the timeout counter, and set the last-served pointer so that read goes first.
REQ-022 Reset output values: RD=1, WR=0, RB=1, WA=1, D1=0, D2=0.
REQ-023 Reset asserted mid-sequence SHALL abort the sequence immediately, with no further strobes.

Verification
REQ-024 Idle: FFA=0, EFB=0, RXF=1, TXE=1 for 50 clocks -> outputs stay at reset values and no strobe toggles.
REQ-025 USB write: FFA=1, EFB=1, RXF=1, TXE=0; bench raises TXE for 630 time units after each WR falling edge, 20 times -> 20 RB pulses, 20 WR pulses, D1=1 only during the write sequences.
REQ-026 USB read: FFA=1, EFB=0, RXF=0, TXE=1; bench raises RXF after each RD rising edge, 40 times -> 40 RD pulses, each 2 clocks low, 40 WA pulses inside the RD-low window, D2=1 only during the read sequences.
REQ-027 Both requests held true -> read and write sequences alternate, starting with read; D1/D2 and RD/WR exclusivity hold on every clock.
REQ-028 TXE held at 0 after a write -> W_WAIT exits after 8 clocks and the next byte starts; FFA=0 with RXF=0 -> no RD activity.
REQ-029 rst_n=0 asserted during R_CAPTURE -> next edge gives RD=1, WA=1, D2=0, state IDLE.
